nibble_serial_adder: RTL and testbench

Sequential multi-word adder that sits directly upstream of the existing 4-bit carry-lookahead adder (`CarryLookAheadAdder`) and drives it. It accepts a wide operand pair on a start strobe and feeds the CLA one nibble per clock, least significant first. It registers each 4-bit sum and chains the CLA carry-out back into the next nibble's carry-in. It then presents the full-width sum, carry-out and signed overflow with a one-cycle done pulse.

---
 rtl/nibble_serial_adder.sv | 175 +++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-word adder that walks a wide operand pair
// through a single 4-bit carry-lookahead adder, one nibble per clock,
// least significant nibble first, and presents sum/cout/overflow with a
// one-cycle done pulse.
//
// Handshake: start is sampled only while idle (busy=0). The edge that
// samples start high is the accepting edge; a, b and cin are captured
// there and may change afterwards. done is a single-cycle pulse during
// which sum/cout/overflow are valid. They are then held until the next
// operation's final edge. start seen while busy is dropped, not queued.

// 4-bit carry-lookahead adder slice.
module CarryLookAheadAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Lookahead carries, each computed directly from generate/propagate.
  always_comb begin
    w_c[0] = Cin;
    w_c[1] = w_g[0] | (w_p[0] & Cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & Cin);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);
  end

  assign S    = w_p ^ w_c[3:0];
  assign Cout = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 overflow,
  output logic [1:0]           dbg_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_psum;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_s;
  logic            w_co;
  logic            w_last;
  logic [W-1:0]    w_psum_next;
  logic            w_ovf;

  // Current nibble of the captured operands feeds the CLA.
  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];
  assign w_last  = (r_idx == IW'(NIBBLES - 1));

  CarryLookAheadAdder u_cla (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_co)
  );

  // Partial sum with the current CLA nibble merged in; on the last edge
  // this is the complete result, so sum and overflow are taken from it.
  always_comb begin
    w_psum_next = r_psum;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IW'(i)) w_psum_next[4*i +: 4] = w_s;
    end
  end

  assign w_ovf = (r_a[W-1] == r_b[W-1]) && (w_psum_next[W-1] != r_a[W-1]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADD;
      S_ADD:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register.
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    dbg_state = r_state;
  end

  // Datapath: operand capture, per-nibble accumulate, result publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_psum  <= '0;
          end
        end
        S_ADD: begin
          r_psum  <= w_psum_next;
          r_carry <= w_co;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_sum  <= w_psum_next;
            r_cout <= w_co;
            r_ovf  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a 4-nibble instance driven with directed
// and random operations, and a 1-nibble instance swept exhaustively.
module tb_nibble_serial_adder;
  localparam int N4 = 4;
  localparam int W4 = 16;
  localparam int RW = W4 + 2;
  localparam int RW1 = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-nibble instance
  logic          s4_start, s4_cin;
  logic [W4-1:0] s4_a, s4_b;
  logic          busy4, done4, cout4, ovf4;
  logic [W4-1:0] sum4;
  logic [1:0]    dbg4;

  // 1-nibble instance
  logic          s1_start, s1_cin;
  logic [3:0]    s1_a, s1_b;
  logic          busy1, done1, cout1, ovf1;
  logic [3:0]    sum1;
  logic [1:0]    dbg1;

  nibble_serial_adder #(.NIBBLES(N4)) dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b), .cin(s4_cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4),
    .dbg_state(dbg4)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1),
    .dbg_state(dbg1)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboards: expected {cout, overflow, sum} plus the cycle at which done
  // must be seen; held_* is the result the outputs must show between dones.
  logic [RW-1:0]  exp_q[$];
  int             cyc_q[$];
  logic [RW-1:0]  held4;
  logic [RW1-1:0] exp1_q[$];
  int             cyc1_q[$];
  logic [RW1-1:0] held1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic for a w-bit add with carry in.
  task automatic ref_add(input int w, input int a, input int b, input int ci,
                         output int s, output bit co, output bit ov);
    int tot, sa, sb, st, lim;
    lim = 1 << w;
    tot = a + b + ci;
    s   = tot % lim;
    co  = (tot >= lim);
    sa  = (a >= lim / 2) ? a - lim : a;
    sb  = (b >= lim / 2) ? b - lim : b;
    st  = sa + sb + ci;
    ov  = (st >= lim / 2) || (st < -(lim / 2));
  endtask

  // Monitor for the 4-nibble instance.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    int c;
    if (!rst) begin
      if (done4) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done4 actual=done required=no_done (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          chk("result4", {cout4, ovf4, sum4}, e);
          chk("latency4", cyc, c);
          chk("busy_in_done4", busy4, 1'b1);
          held4 = e;
        end
      end else begin
        chk("hold4", {cout4, ovf4, sum4}, held4);
      end
    end
  end

  // Monitor for the 1-nibble instance.
  always @(negedge clk) begin
    logic [RW1-1:0] e;
    int c;
    if (!rst) begin
      if (done1) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done1 actual=done required=no_done (t=%0t)", $time);
        end else begin
          e = exp1_q.pop_front();
          c = cyc1_q.pop_front();
          chk("result1", {cout1, ovf1, sum1}, e);
          chk("latency1", cyc, c);
          held1 = e;
        end
      end else begin
        chk("hold1", {cout1, ovf1, sum1}, held1);
      end
    end
  end

  // Asserts reset mid-cycle and checks outputs clear immediately.
  // Returns at a negedge with reset released.
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete(); cyc_q.delete(); held4 = '0;
    exp1_q.delete(); cyc1_q.delete(); held1 = '0;
    #1;
    chk("rst_out4", {busy4, done4, cout4, ovf4, sum4}, '0);
    chk("rst_out1", {busy1, done1, cout1, ovf1, sum1}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one operation on the 4-nibble instance at the current negedge and
  // returns at the first negedge where a new start would be accepted.
  // pester re-raises start with junk operands during ADD and during DONE.
  task automatic issue4(input logic [W4-1:0] a, input logic [W4-1:0] b,
                        input logic ci, input bit pester);
    int s; bit co, ov;
    ref_add(W4, int'(a), int'(b), int'(ci), s, co, ov);
    exp_q.push_back({co, ov, s[W4-1:0]});
    cyc_q.push_back(cyc + 1 + N4);
    s4_start = 1'b1; s4_a = a; s4_b = b; s4_cin = ci;
    for (int k = 1; k <= N4 + 2; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_after_accept4", busy4, 1'b1);
      if (pester && (k == 2 || k == N4 + 1)) begin
        s4_start = 1'b1; s4_a = 16'hFFFF; s4_b = 16'hFFFF; s4_cin = 1'b1;
      end else begin
        s4_start = 1'b0; s4_a = W4'($urandom); s4_b = W4'($urandom);
        s4_cin = 1'($urandom);
      end
    end
  endtask

  task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int s; bit co, ov;
    ref_add(4, int'(a), int'(b), int'(ci), s, co, ov);
    exp1_q.push_back({co, ov, s[3:0]});
    cyc1_q.push_back(cyc + 2);
    s1_start = 1'b1; s1_a = a; s1_b = b; s1_cin = ci;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      s1_start = 1'b0; s1_a = 4'($urandom); s1_b = 4'($urandom);
      s1_cin = 1'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    held4 = '0; held1 = '0;
    s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_cin = 1'b0;
    s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("por_out4", {busy4, done4, cout4, ovf4, sum4}, '0);
    rst = 1'b0;
    @(negedge clk);

    do_reset();
    issue4(16'h1234, 16'h4321, 1'b0, 1'b0);
    issue4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue4(16'h0000, 16'h0000, 1'b1, 1'b0);
    issue4(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue4(16'h8000, 16'h8000, 1'b0, 1'b0);
    issue4(16'h000B, 16'h0006, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    issue4(16'h0100, 16'h0200, 1'b0, 1'b0);

    // Reset two ADD edges into an operation: it must vanish without done.
    s4_start = 1'b1; s4_a = 16'h1111; s4_b = 16'h2222; s4_cin = 1'b0;
    @(negedge clk);
    s4_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_midrst4", busy4, 1'b1);
    #2 rst = 1'b1;
    exp_q.delete(); cyc_q.delete(); held4 = '0;
    #1;
    chk("midrst_out4", {busy4, done4, cout4, ovf4, sum4}, '0);
    @(negedge clk);
    rst = 1'b0;
    issue4(16'h0005, 16'h0003, 1'b1, 1'b0);

    // Random operations with random idle gaps between them.
    for (int i = 0; i < 40; i++) begin
      logic [W4-1:0] ra, rb;
      ra = W4'($urandom); rb = W4'($urandom);
      if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h8000;
      issue4(ra, rb, 1'($urandom), ($urandom_range(0, 4) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Exhaustive sweep of the single-nibble instance.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          issue1(4'(ia), 4'(ib), 1'(ic));

    repeat (4) @(negedge clk);
    chk("drained4", exp_q.size(), 0);
    chk("drained1", exp1_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
